approx_log_multiplier_pipe: RTL and testbench
=============================================

Name: approx_log_multiplier_pipe

Overview:
- Parametrised, pipelined successor to the combinational Mitchell-style approximate log multiplier.
- Signed WIDTH x WIDTH multiply with dynamic truncation of the log fraction to T bits.
- Adds a per-transaction exact/approximate mode select, a sideband tag, and valid/ready flow control.
- Sits between the operand buffers and the accumulator in the multiplier/MAC datapath.

Parameters:
- WIDTH, 8, operand width (signed two's complement), >= 4.
- T, 4, truncated log-fraction width (T-1 kept fraction bits plus a forced 1), 2 <= T <= WIDTH.
- STAGES, 3, pipeline register stages between input acceptance and output, 1..4.
- TAG_W, 4, sideband tag width, carried unchanged.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block accepts this cycle.
- in_a  in  WIDTH  signed operand A.
- in_b  in  WIDTH  signed operand B.
- in_exact  in  1  1 = exact product, 0 = approximate.
- in_tag  in  TAG_W  sideband, returned with the result.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts.
- out_result  out  2*WIDTH  signed product.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Reset (rst_n=0 at a clk edge): all stage valids, out_valid, out_result and out_tag become 0. In-flight data is discarded. in_ready = 1 during and after reset.
- Advance enable: en = !out_valid || out_ready. in_ready = en, combinational.
- Transfer occurs when in_valid && in_ready. When en = 0, every stage holds its valid, data, mode and tag.
- Latency: an accepted pair appears on out_valid exactly STAGES cycles later if out_ready is held 1.
- Throughput: 1 per cycle. Stage bubbles propagate as valid = 0. With out_ready = 0, out_valid and its data hold stable.
- Sign/zero: zero_flag = (a == 0) || (b == 0). sign = a[MSB] ^ b[MSB]. abs values are WIDTH-bit unsigned, so the most negative value maps to 2^(WIDTH-1).
- LOD: k = index of the leading one of abs. x = bits below that leading one, left-aligned and zero-padded to WIDTH-1 bits.
- Dynamic truncation: x_t = {x[WIDTH-2 -: T-1], 1'b1}.
- Log value: L = k*2^T + x_t. S = L_A + L_B, computed without overflow.
- Antilog: K = S >> T, F = S[T-1:0], magnitude M = ((2^T + F) << K) >> T.
- Saturation: if M > 2^(2*WIDTH-1) - 1, M = 2^(2*WIDTH-1) - 1.
- Result: out_result = 0 if zero_flag; otherwise -M if sign is set, else M.
- Exact mode (in_exact = 1): out_result = a*b (full signed product). Same latency and the same pipeline slot as approximate mode.
- Mode and tag travel with their data. Mixed-mode back-to-back streams must not interfere.
- Stage split when STAGES >= 3: stage 1 does sign/abs/LOD; stage 2 does truncation/log/add; stage 3 does antilog/sign-set. Any extra stages are output retiming. The stage split is not visible at the ports.
- Simultaneous events: an output handshake and an input accept in the same cycle are both honoured, so a full pipeline keeps streaming.
- Reset asserted mid-stream drops everything in flight; no partial result is ever emitted.

Test Plan:
- Defaults, out_ready=1, approx: a=3, b=3 -> out_result=9 at cycle +3. a=-5, b=7 -> -36, next cycle after it.
- Approx, most-negative operands: a=-128, b=-128 -> 18432. a=0, b=-77 -> 0. a=1, b=1 -> 1.
- Exact mode: a=-5, b=7 -> -35. a=-128, b=-128 -> 16384. Interleave with the approx a=3, b=3 and check the results and tags pair up correctly (tags 1, 2, 3).
- Backpressure: stream 6 pairs and hold out_ready=0 for 5 cycles from cycle 4. Required: in_ready=0 while the pipeline is full; out_result/out_tag stay stable; all 6 results emerge in order with no loss or duplication.
- Reset: assert rst_n=0 for 1 cycle with 3 transactions in flight. Required: out_valid=0 next cycle, the dropped results never appear, in_ready=1.
- Sweep: all 65536 operand pairs, random valid/ready. Compare against a reference model of the approx formula, and against a*b in exact mode; with T=WIDTH and STAGES=1, check the sweep again.

Source files
------------

// File: rtl/approx_log_multiplier_pipe.sv
`default_nettype none
// ============================================================================
// Module   : approx_log_multiplier_pipe
// Purpose  : Pipelined signed WIDTH x WIDTH multiplier. Each transaction picks
//            either the exact product or a Mitchell-style log-domain
//            approximation whose log fraction is truncated to T bits (T-1 kept
//            bits plus a forced 1). A sideband tag travels with every result.
//            Valid/ready flow control with a single global advance enable.
// Ports    : clk        - clock, rising edge
//            rst_n      - synchronous active-low reset
//            in_valid   - operand pair present
//            in_ready   - block accepts this cycle (combinational)
//            in_a/in_b  - signed operands, WIDTH bits
//            in_exact   - 1 = exact product, 0 = approximate
//            in_tag     - sideband tag, TAG_W bits
//            out_valid  - result present
//            out_ready  - downstream accepts
//            out_result - signed product, 2*WIDTH bits
//            out_tag    - tag of this result
// Revision : 1.0 - initial release
// ============================================================================
module approx_log_multiplier_pipe #(
   parameter int WIDTH  = 8,
   parameter int T      = 4,
   parameter int STAGES = 3,
   parameter int TAG_W  = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic               in_exact,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_result,
   output logic [TAG_W-1:0]   out_tag
);
   localparam int c_kw  = $clog2(WIDTH);     // leading-one index width
   localparam int c_xw  = WIDTH - 1;         // fraction below the leading one
   localparam int c_sw  = 1 + c_kw + T;      // sum of two log values
   localparam int c_mw  = T + 2*WIDTH;       // antilog before the final >>T
   localparam int c_pw  = 2*WIDTH;           // product width
   localparam int c_nrt = (STAGES > 3) ? STAGES - 3 : 0;
   localparam logic [c_kw-1:0] c_kmax = c_kw'(WIDTH - 1);
   localparam logic [c_mw-1:0] c_sat  = {{(T+1){1'b0}}, {(c_pw-1){1'b1}}};

   typedef struct packed {
      logic             valid;
      logic             exact;
      logic [TAG_W-1:0] tag;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             zero;
      logic             sign;
      logic [c_kw-1:0]  ka;
      logic [c_kw-1:0]  kb;
      logic [c_xw-1:0]  xa;
      logic [c_xw-1:0]  xb;
   } s1_t;

   typedef struct packed {
      logic             valid;
      logic             exact;
      logic [TAG_W-1:0] tag;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             zero;
      logic             sign;
      logic [c_sw-1:0]  s;
   } s2_t;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [c_pw-1:0]  result;
   } s3_t;

   function automatic logic [c_kw-1:0] lead_one(input logic [WIDTH-1:0] v);
      lead_one = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) lead_one = c_kw'(i);
      end
   endfunction

   // Whole pipeline advances together; a held output freezes every stage.
   logic w_en;
   assign w_en     = !out_valid || out_ready;
   assign in_ready = w_en;

   // ---------------- stage 1: sign / abs / leading-one detect --------------
   s1_t              w_s1_d, w_s1_q;
   logic [WIDTH-1:0] w_abs_a, w_abs_b;

   always_comb begin
      // Unsigned WIDTH-bit abs: the most negative value maps to 2^(WIDTH-1).
      w_abs_a      = in_a[WIDTH-1] ? -in_a : in_a;
      w_abs_b      = in_b[WIDTH-1] ? -in_b : in_b;
      w_s1_d       = '0;
      w_s1_d.valid = in_valid;
      w_s1_d.exact = in_exact;
      w_s1_d.tag   = in_tag;
      w_s1_d.a     = in_a;
      w_s1_d.b     = in_b;
      w_s1_d.zero  = (in_a == '0) || (in_b == '0);
      w_s1_d.sign  = in_a[WIDTH-1] ^ in_b[WIDTH-1];
      w_s1_d.ka    = lead_one(w_abs_a);
      w_s1_d.kb    = lead_one(w_abs_b);
      // Shift the leading one up to the MSB; what remains below it is x.
      w_s1_d.xa    = c_xw'(w_abs_a << (c_kmax - w_s1_d.ka));
      w_s1_d.xb    = c_xw'(w_abs_b << (c_kmax - w_s1_d.kb));
   end

   generate
      if (STAGES >= 3) begin : g_reg1
         s1_t r_s1;
         always_ff @(posedge clk) begin
            if (!rst_n)    r_s1 <= '0;
            else if (w_en) r_s1 <= w_s1_d;
         end
         assign w_s1_q = r_s1;
      end else begin : g_pass1
         assign w_s1_q = w_s1_d;
      end
   endgenerate

   // ---------------- stage 2: truncation / log / add ------------------------
   s2_t          w_s2_d, w_s2_q;
   logic [T-1:0] w_xt_a, w_xt_b;
   logic         w_unused_x;

   // Fraction bits below the truncation point are intentionally dropped.
   assign w_unused_x = ^{w_s1_q.xa, w_s1_q.xb};

   always_comb begin
      w_xt_a       = {w_s1_q.xa[c_xw-1 -: T-1], 1'b1};
      w_xt_b       = {w_s1_q.xb[c_xw-1 -: T-1], 1'b1};
      w_s2_d       = '0;
      w_s2_d.valid = w_s1_q.valid;
      w_s2_d.exact = w_s1_q.exact;
      w_s2_d.tag   = w_s1_q.tag;
      w_s2_d.a     = w_s1_q.a;
      w_s2_d.b     = w_s1_q.b;
      w_s2_d.zero  = w_s1_q.zero;
      w_s2_d.sign  = w_s1_q.sign;
      // L = k*2^T + x_t is just the concatenation {k, x_t}.
      w_s2_d.s     = {1'b0, w_s1_q.ka, w_xt_a} + {1'b0, w_s1_q.kb, w_xt_b};
   end

   generate
      if (STAGES >= 2) begin : g_reg2
         s2_t r_s2;
         always_ff @(posedge clk) begin
            if (!rst_n)    r_s2 <= '0;
            else if (w_en) r_s2 <= w_s2_d;
         end
         assign w_s2_q = r_s2;
      end else begin : g_pass2
         assign w_s2_q = w_s2_d;
      end
   endgenerate

   // ---------------- stage 3: antilog / saturate / sign-set -----------------
   s3_t             w_s3_d, r_s3;
   logic [c_kw:0]   w_k;
   logic [T-1:0]    w_f;
   logic [c_mw-1:0] w_m;
   logic [c_pw-1:0] w_mag, w_prod;

   always_comb begin
      w_k    = w_s2_q.s[c_sw-1:T];
      w_f    = w_s2_q.s[T-1:0];
      w_m    = (c_mw'({1'b1, w_f}) << w_k) >> T;
      w_mag  = (w_m > c_sat) ? {1'b0, {(c_pw-1){1'b1}}} : c_pw'(w_m);
      // Low 2*WIDTH bits of the sign-extended product are the signed product.
      w_prod = {{WIDTH{w_s2_q.a[WIDTH-1]}}, w_s2_q.a} *
               {{WIDTH{w_s2_q.b[WIDTH-1]}}, w_s2_q.b};
      w_s3_d       = '0;
      w_s3_d.valid = w_s2_q.valid;
      w_s3_d.tag   = w_s2_q.tag;
      if (w_s2_q.exact)     w_s3_d.result = w_prod;
      else if (w_s2_q.zero) w_s3_d.result = '0;
      else if (w_s2_q.sign) w_s3_d.result = -w_mag;
      else                  w_s3_d.result = w_mag;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)    r_s3 <= '0;
      else if (w_en) r_s3 <= w_s3_d;
   end

   // ---------------- optional output retiming -------------------------------
   s3_t w_chain [c_nrt+1];
   assign w_chain[0] = r_s3;

   generate
      for (genvar g = 0; g < c_nrt; g++) begin : g_retime
         s3_t r_rt;
         always_ff @(posedge clk) begin
            if (!rst_n)    r_rt <= '0;
            else if (w_en) r_rt <= w_chain[g];
         end
         assign w_chain[g+1] = r_rt;
      end
   endgenerate

   assign out_valid  = w_chain[c_nrt].valid;
   assign out_tag    = w_chain[c_nrt].tag;
   assign out_result = w_chain[c_nrt].result;

endmodule
`default_nettype wire

// File: tb/tb_approx_log_multiplier_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_approx_log_multiplier_pipe
// Purpose  : Self-checking bench for approx_log_multiplier_pipe. Directed
//            scenarios on the default configuration plus a full operand sweep
//            on the default and on a T=WIDTH, STAGES=1 configuration, checked
//            against an arithmetic model of the log-multiply rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_approx_log_multiplier_pipe;
   localparam int WIDTH   = 8;
   localparam int T       = 4;
   localparam int STAGES  = 3;
   localparam int TAG_W   = 4;
   localparam int T2      = 8;
   localparam int STAGES2 = 1;
   localparam int N_SWEEP = 65536;
   localparam int BUDGET  = 90000;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst_n;
   logic               in_valid, in_ready, in_exact, out_valid, out_ready;
   logic [WIDTH-1:0]   in_a, in_b;
   logic [TAG_W-1:0]   in_tag, out_tag;
   logic [2*WIDTH-1:0] out_result;

   logic               d2_in_valid, d2_in_ready, d2_in_exact, d2_out_valid, d2_out_ready;
   logic [WIDTH-1:0]   d2_in_a, d2_in_b;
   logic [TAG_W-1:0]   d2_in_tag, d2_out_tag;
   logic [2*WIDTH-1:0] d2_out_result;

   int total = 0;
   int bad   = 0;

   logic [2*WIDTH-1:0] q1_r[$], q2_r[$];
   logic [TAG_W-1:0]   q1_t[$], q2_t[$];

   approx_log_multiplier_pipe #(.WIDTH(WIDTH), .T(T), .STAGES(STAGES), .TAG_W(TAG_W)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .in_exact(in_exact), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag)
   );

   approx_log_multiplier_pipe #(.WIDTH(WIDTH), .T(T2), .STAGES(STAGES2), .TAG_W(TAG_W)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_a(d2_in_a), .in_b(d2_in_b),
      .in_exact(d2_in_exact), .in_tag(d2_in_tag),
      .out_valid(d2_out_valid), .out_ready(d2_out_ready),
      .out_result(d2_out_result), .out_tag(d2_out_tag)
   );

   // Log value of a positive magnitude u: k*2^t plus the truncated fraction.
   function automatic int log_val(input int u, input int w, input int t);
      int k, frac, x, top;
      k = 0;
      while ((u >> (k + 1)) != 0) k++;
      frac = u - (1 << k);
      x    = frac << (w - 1 - k);   // w-1 bit left-aligned fraction
      top  = x >> (w - t);          // keep the top t-1 bits
      return k * (1 << t) + top * 2 + 1;
   endfunction

   function automatic logic [2*WIDTH-1:0] model(input int a, input int b, input bit exact, input int t);
      int     s, kk, ff;
      longint m, lim;
      if (exact) return (2*WIDTH)'(a * b);
      if (a == 0 || b == 0) return '0;
      s   = log_val(a < 0 ? -a : a, WIDTH, t) + log_val(b < 0 ? -b : b, WIDTH, t);
      kk  = s >> t;
      ff  = s % (1 << t);
      m   = (longint'((1 << t) + ff) << kk) >> t;
      lim = (longint'(1) << (2*WIDTH - 1)) - 1;
      if (m > lim) m = lim;
      if ((a < 0) != (b < 0)) m = -m;
      return (2*WIDTH)'(m);
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || out_result !== '0 || out_tag !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got valid=%0b result=%0d tag=%0d want 0/0/0", out_valid, out_result, out_tag);
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_ready: got %0b want 1", in_ready);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_approx_basic();
      logic [7:0]  av [5] = '{8'd3, 8'hFB, 8'h80, 8'd0,  8'd1};
      logic [7:0]  bv [5] = '{8'd3, 8'd7,  8'h80, 8'hB3, 8'd1};
      logic [15:0] ev [5] = '{16'd9, 16'hFFDC, 16'd18432, 16'd0, 16'd1};
      int got = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 5 + STAGES + 3; c++) begin
         @(posedge clk); #1;
         in_valid = (c < 5);
         if (c < 5) begin
            in_a = av[c]; in_b = bv[c]; in_exact = 1'b0; in_tag = TAG_W'(c + 1);
         end
         @(negedge clk);
         if (out_valid) begin
            total++;
            if (got >= 5) begin
               bad++;
               $display("FAIL approx_extra: got result=%0d at cycle %0d want no output", $signed(out_result), c);
            end else if (c != got + STAGES || out_result !== ev[got] || out_tag !== TAG_W'(got + 1)) begin
               bad++;
               $display("FAIL approx_basic[%0d]: got result=%0d tag=%0d cycle=%0d want result=%0d tag=%0d cycle=%0d",
                        got, $signed(out_result), out_tag, c, $signed(ev[got]), got + 1, got + STAGES);
            end
            got++;
         end
      end
      total++;
      if (got != 5) begin
         bad++;
         $display("FAIL approx_count: got %0d want 5", got);
      end
   endtask

   task automatic test_exact_mixed();
      logic [7:0]  av [3] = '{8'hFB, 8'd3, 8'h80};
      logic [7:0]  bv [3] = '{8'd7,  8'd3, 8'h80};
      logic        xv [3] = '{1'b1,  1'b0, 1'b1};
      logic [15:0] ev [3] = '{16'hFFDD, 16'd9, 16'd16384};
      int got = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 3 + STAGES + 3; c++) begin
         @(posedge clk); #1;
         in_valid = (c < 3);
         if (c < 3) begin
            in_a = av[c]; in_b = bv[c]; in_exact = xv[c]; in_tag = TAG_W'(c + 1);
         end
         @(negedge clk);
         if (out_valid) begin
            total++;
            if (got >= 3) begin
               bad++;
               $display("FAIL mixed_extra: got result=%0d want no output", $signed(out_result));
            end else if (c != got + STAGES || out_result !== ev[got] || out_tag !== TAG_W'(got + 1)) begin
               bad++;
               $display("FAIL mixed[%0d]: got result=%0d tag=%0d cycle=%0d want result=%0d tag=%0d cycle=%0d",
                        got, $signed(out_result), out_tag, c, $signed(ev[got]), got + 1, got + STAGES);
            end
            got++;
         end
      end
      total++;
      if (got != 3) begin
         bad++;
         $display("FAIL mixed_count: got %0d want 3", got);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0]  pa [6];
      logic [7:0]  pb [6];
      logic        pe [6];
      logic [15:0] er [6];
      int sent = 0, got = 0;
      logic pv = 1'b0, pr = 1'b1;
      logic [15:0] pres = '0;
      logic [3:0]  ptag = '0;
      for (int j = 0; j < 6; j++) begin
         pa[j] = 8'($urandom);
         pb[j] = 8'($urandom);
         pe[j] = 1'($urandom_range(0, 1));
         er[j] = model($signed(pa[j]), $signed(pb[j]), pe[j], T);
      end
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         out_ready = !(c >= 4 && c < 9);
         in_valid  = (sent < 6);
         if (sent < 6) begin
            in_a = pa[sent]; in_b = pb[sent]; in_exact = pe[sent]; in_tag = TAG_W'(sent + 1);
         end
         @(negedge clk);
         if (pv && !pr) begin
            total++;
            if (out_valid !== 1'b1 || out_result !== pres || out_tag !== ptag) begin
               bad++;
               $display("FAIL bp_hold: got valid=%0b result=%0d tag=%0d want 1/%0d/%0d",
                        out_valid, $signed(out_result), out_tag, $signed(pres), ptag);
            end
         end
         if (out_valid && !out_ready) begin
            total++;
            if (in_ready !== 1'b0) begin
               bad++;
               $display("FAIL bp_in_ready: got %0b want 0 at cycle %0d", in_ready, c);
            end
         end
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) begin
            total++;
            if (got >= 6) begin
               bad++;
               $display("FAIL bp_extra: got result=%0d tag=%0d want no output", $signed(out_result), out_tag);
            end else if (out_result !== er[got] || out_tag !== TAG_W'(got + 1)) begin
               bad++;
               $display("FAIL bp_order[%0d]: got result=%0d tag=%0d want result=%0d tag=%0d",
                        got, $signed(out_result), out_tag, $signed(er[got]), got + 1);
            end
            got++;
         end
         pv = out_valid; pr = out_ready; pres = out_result; ptag = out_tag;
      end
      total++;
      if (got != 6) begin
         bad++;
         $display("FAIL bp_count: got %0d want 6", got);
      end
      out_ready = 1'b1;
   endtask

   task automatic test_reset_midstream();
      bit seen  = 1'b0;
      bit found = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         in_valid = (c < 3);
         in_a = 8'(c + 2); in_b = 8'd5; in_exact = 1'b0; in_tag = TAG_W'(c + 4);
         if (c == 3) begin
            out_ready = 1'b0;
            rst_n     = 1'b0;
         end
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid_inflight: got valid=%0b want 1", out_valid);
      end
      @(posedge clk); #1;
      rst_n = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid_after: got valid=%0b ready=%0b want 0/1", out_valid, in_ready);
      end
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL rst_mid_dropped: got a dropped result emerging want none");
      end
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = 8'd1; in_b = 8'd1; in_exact = 1'b0; in_tag = 4'd9;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         @(negedge clk);
         if (out_valid) found = 1'b1;
      end
      total++;
      if (!found || out_result !== 16'd1 || out_tag !== 4'd9) begin
         bad++;
         $display("FAIL rst_mid_resume: got found=%0b result=%0d tag=%0d want 1/1/9", found, $signed(out_result), out_tag);
      end
   endtask

   task automatic test_sweep();
      q1_r.delete(); q1_t.delete(); q2_r.delete(); q2_t.delete();
      fork
         begin : drv1
            int i = 0, cyc = 0;
            logic [7:0] a, b;
            logic e;
            while (i < N_SWEEP && cyc < BUDGET) begin
               @(posedge clk); #1;
               cyc++;
               a = i[15:8]; b = i[7:0]; e = 1'($urandom_range(0, 1));
               in_valid = ($urandom_range(0, 63) != 0);
               in_a = a; in_b = b; in_exact = e; in_tag = i[3:0];
               out_ready = ($urandom_range(0, 63) != 0);
               @(negedge clk);
               if (in_valid && in_ready) begin
                  q1_r.push_back(model($signed(a), $signed(b), e, T));
                  q1_t.push_back(i[3:0]);
                  i++;
               end
            end
            @(posedge clk); #1;
            in_valid = 1'b0; out_ready = 1'b1;
            total++;
            if (i != N_SWEEP) begin
               bad++;
               $display("FAIL sweep1_feed: got %0d accepted want %0d", i, N_SWEEP);
            end
         end
         begin : mon1
            int got = 0, cyc = 0;
            logic [15:0] er;
            logic [3:0]  et;
            while (got < N_SWEEP && cyc < BUDGET + 50) begin
               @(negedge clk);
               cyc++;
               if (out_valid && out_ready) begin
                  total++;
                  if (q1_r.size() == 0) begin
                     bad++;
                     $display("FAIL sweep1_extra: got result=%0d want none", $signed(out_result));
                  end else begin
                     er = q1_r.pop_front(); et = q1_t.pop_front();
                     if (out_result !== er || out_tag !== et) begin
                        bad++;
                        $display("FAIL sweep1[%0d]: got result=%0d tag=%0d want result=%0d tag=%0d",
                                 got, $signed(out_result), out_tag, $signed(er), et);
                     end
                  end
                  got++;
               end
            end
            total++;
            if (got != N_SWEEP) begin
               bad++;
               $display("FAIL sweep1_count: got %0d want %0d", got, N_SWEEP);
            end
         end
         begin : drv2
            int i = 0, cyc = 0;
            logic [7:0] a, b;
            logic e;
            while (i < N_SWEEP && cyc < BUDGET) begin
               @(posedge clk); #1;
               cyc++;
               a = i[7:0]; b = i[15:8]; e = 1'($urandom_range(0, 1));
               d2_in_valid = ($urandom_range(0, 63) != 0);
               d2_in_a = a; d2_in_b = b; d2_in_exact = e; d2_in_tag = i[3:0];
               d2_out_ready = ($urandom_range(0, 63) != 0);
               @(negedge clk);
               if (d2_in_valid && d2_in_ready) begin
                  q2_r.push_back(model($signed(a), $signed(b), e, T2));
                  q2_t.push_back(i[3:0]);
                  i++;
               end
            end
            @(posedge clk); #1;
            d2_in_valid = 1'b0; d2_out_ready = 1'b1;
            total++;
            if (i != N_SWEEP) begin
               bad++;
               $display("FAIL sweep2_feed: got %0d accepted want %0d", i, N_SWEEP);
            end
         end
         begin : mon2
            int got = 0, cyc = 0;
            logic [15:0] er;
            logic [3:0]  et;
            while (got < N_SWEEP && cyc < BUDGET + 50) begin
               @(negedge clk);
               cyc++;
               if (d2_out_valid && d2_out_ready) begin
                  total++;
                  if (q2_r.size() == 0) begin
                     bad++;
                     $display("FAIL sweep2_extra: got result=%0d want none", $signed(d2_out_result));
                  end else begin
                     er = q2_r.pop_front(); et = q2_t.pop_front();
                     if (d2_out_result !== er || d2_out_tag !== et) begin
                        bad++;
                        $display("FAIL sweep2[%0d]: got result=%0d tag=%0d want result=%0d tag=%0d",
                                 got, $signed(d2_out_result), d2_out_tag, $signed(er), et);
                     end
                  end
                  got++;
               end
            end
            total++;
            if (got != N_SWEEP) begin
               bad++;
               $display("FAIL sweep2_count: got %0d want %0d", got, N_SWEEP);
            end
         end
      join
   endtask

   initial begin
      rst_n       = 1'b0;
      in_valid    = 1'b0; in_a = '0; in_b = '0; in_exact = 1'b0; in_tag = '0; out_ready = 1'b1;
      d2_in_valid = 1'b0; d2_in_a = '0; d2_in_b = '0; d2_in_exact = 1'b0; d2_in_tag = '0; d2_out_ready = 1'b1;
      test_reset();
      test_approx_basic();
      test_exact_mixed();
      test_backpressure();
      test_reset_midstream();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
